// File: rtl/phy_pkg.sv
// Purpose: constants and aligner state encoding shared by the PHY transmitter and receiver.
// Latency: none, this file holds declarations only.
// Backpressure: none.
package phy_pkg;

   localparam logic [7:0] PHY_COM_SYM  = 8'hBC;
   localparam logic [7:0] PHY_IDLE_SYM = 8'h7C;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } phy_state_e;

endpackage

// File: rtl/phy_rx_aligner.sv
// Purpose: recovers symbol alignment from the serial stream by COM hunting; PHY_RX_LOSS_DET_EN adds a COM-gap loss-of-lock detector.
// Latency: sym_next is combinational; strobe/lock reflect the edge that samples the symbol's last bit.
// Backpressure: none, the serial stream is consumed every clock.
module phy_rx_aligner
   import phy_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(PHY_COM_SYM),
   parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(PHY_IDLE_SYM),
   parameter int               LOCK_COUNT = 4,
   parameter int               GAP_LIMIT  = 64
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic             serial_in,
   output logic [WIDTH-1:0] sym_next,
   output logic             sym_strobe,
   output logic             sym_is_data,
   output logic             lock
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(LOCK_COUNT + 1);

   phy_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q;
   logic [BW-1:0]    bit_cnt_q;
   logic [CW-1:0]    com_cnt_q;
   logic             boundary;
   logic             is_com;
   logic             is_idle;
   logic             loss;
   logic             unused_bits;

   assign sym_next    = {shift_q[WIDTH-2:0], serial_in};
   assign boundary    = (bit_cnt_q == BW'(WIDTH - 1));
   assign is_com      = (sym_next == COM_SYM);
   assign is_idle     = (sym_next == IDLE_SYM);
   assign sym_is_data = !is_com && !is_idle;

`ifdef PHY_RX_LOSS_DET_EN
   localparam int GW = $clog2(GAP_LIMIT + 1);

   logic [GW-1:0] gap_cnt_q;

   // A non-COM boundary that would push the gap past its limit drops lock.
   assign loss = (state_q == ST_LOCKED) && boundary && !is_com &&
                 (gap_cnt_q == GW'(GAP_LIMIT));
   assign unused_bits = shift_q[WIDTH-1];

   // Gap counter: symbols since the last COM while locked.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         gap_cnt_q <= '0;
      end else if ((state_q != ST_LOCKED) || loss || (boundary && is_com)) begin
         gap_cnt_q <= '0;
      end else if (boundary) begin
         gap_cnt_q <= gap_cnt_q + GW'(1);
      end
   end
`else
   assign loss        = 1'b0;
   assign unused_bits = shift_q[WIDTH-1] ^ (^GAP_LIMIT);
`endif

   // Shift register, bit counter (re-phased on a hunted COM) and COM counter.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
      end else begin
         shift_q <= sym_next;
         if ((state_q == ST_SEARCH) && is_com) begin
            bit_cnt_q <= '0;
            com_cnt_q <= CW'(1);
         end else begin
            bit_cnt_q <= boundary ? '0 : bit_cnt_q + BW'(1);
            if ((state_q == ST_ALIGN) && boundary) begin
               com_cnt_q <= is_com ? com_cnt_q + CW'(1) : '0;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: hunt every bit in SEARCH, check only boundaries afterwards.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_SEARCH: begin
            if (is_com) begin
               state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (boundary) begin
               if (!is_com) begin
                  state_d = ST_SEARCH;
               end else if ((com_cnt_q + CW'(1)) == CW'(LOCK_COUNT)) begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (loss) begin
               state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // Outputs: a strobe is offered only for boundaries that keep lock.
   always_comb begin
      lock       = (state_q == ST_LOCKED);
      sym_strobe = lock && boundary && !loss;
   end

endmodule

// File: rtl/phy_rx_link.sv
// Purpose: serial-link receiver top; aligns the bit stream and stripes data symbols round-robin over LANES byte lanes (PHY_RX_LOSS_DET_EN enables loss of lock).
// Latency: lane write and valid strobe are registered on the edge that samples a symbol's last bit.
// Backpressure: none, at most one lane write per WIDTH clocks and no stall input.
module phy_rx_link
   import phy_pkg::*;
#(
   parameter int               LANES      = 4,
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(PHY_COM_SYM),
   parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(PHY_IDLE_SYM),
   parameter int               LOCK_COUNT = 4,
   parameter int               GAP_LIMIT  = 64
) (
   input  logic                   clk_32f,
   input  logic                   reset_L,
   input  logic                   serial_in,
   output logic [LANES*WIDTH-1:0] data_out,
   output logic [LANES-1:0]       valid_out,
   output logic                   idle_out,
   output logic                   locked
);

   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [WIDTH-1:0]            sym_next;
   logic                        sym_strobe;
   logic                        sym_is_data;
   logic                        lock;
   logic [LANES-1:0][WIDTH-1:0] lane_q;
   logic [LANES-1:0]            valid_q;
   logic [PW-1:0]               lane_ptr_q;

   phy_rx_aligner #(
      .WIDTH      (WIDTH),
      .COM_SYM    (COM_SYM),
      .IDLE_SYM   (IDLE_SYM),
      .LOCK_COUNT (LOCK_COUNT),
      .GAP_LIMIT  (GAP_LIMIT)
   ) u_aligner (
      .clk_32f     (clk_32f),
      .reset_L     (reset_L),
      .serial_in   (serial_in),
      .sym_next    (sym_next),
      .sym_strobe  (sym_strobe),
      .sym_is_data (sym_is_data),
      .lock        (lock)
   );

   assign data_out  = lane_q;
   assign valid_out = valid_q;
   assign locked    = lock;
   assign idle_out  = !lock;

   // Striping: data goes to lane_ptr, COM rewinds the pointer, IDLE is dropped.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         lane_q     <= '0;
         valid_q    <= '0;
         lane_ptr_q <= '0;
      end else begin
         valid_q <= '0;
         if (!lock) begin
            lane_ptr_q <= '0;
         end else if (sym_strobe) begin
            if (sym_is_data) begin
               lane_q[lane_ptr_q]  <= sym_next;
               valid_q[lane_ptr_q] <= 1'b1;
               lane_ptr_q <= (lane_ptr_q == PW'(LANES - 1)) ? '0 : lane_ptr_q + PW'(1);
            end else if (sym_next == COM_SYM) begin
               lane_ptr_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_phy_rx_link.sv
// Purpose: directed self-checking bench for phy_rx_link (expectations follow PHY_RX_LOSS_DET_EN).
// Latency: outputs checked 1 time unit after the edge that samples a symbol's last bit.
// Backpressure: none, the bench drives one serial bit per clock.
module tb_phy_rx_link;

   localparam logic [7:0] COM  = 8'hBC;
   localparam logic [7:0] IDLE = 8'h7C;

   logic        clk_32f   = 1'b0;
   logic        reset_L   = 1'b0;
   logic        serial_in = 1'b0;
   logic [31:0] data_out;
   logic [3:0]  valid_out;
   logic        idle_out;
   logic        locked;

   int checks    = 0;
   int errors    = 0;
   int vld_cnt   = 0;
   int multi_cnt = 0;
   int base;

   phy_rx_link #(
      .LANES      (4),
      .WIDTH      (8),
      .COM_SYM    (8'hBC),
      .IDLE_SYM   (8'h7C),
      .LOCK_COUNT (4),
      .GAP_LIMIT  (16)
   ) dut (
      .clk_32f   (clk_32f),
      .reset_L   (reset_L),
      .serial_in (serial_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .idle_out  (idle_out),
      .locked    (locked)
   );

   always #5 clk_32f = ~clk_32f;

   // Count strobe cycles and any cycle with more than one lane strobed.
   always @(posedge clk_32f) begin
      #2;
      if (valid_out != 4'b0000) vld_cnt++;
      if ($countones(valid_out) > 1) multi_cnt++;
   end

   function automatic logic [7:0] lane(input int i);
      return data_out[i*8 +: 8];
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      serial_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_sym(input logic [7:0] s);
      for (int i = 7; i >= 0; i--) send_bit(s[i]);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_32f);
      #1;
      checks++;
      if ({locked, idle_out, valid_out} !== 6'b0_1_0000) begin
         errors++;
         $display("FAIL reset_ctrl: got locked/idle/valid=%b expected 010000", {locked, idle_out, valid_out});
      end
      checks++;
      if (data_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00000000", data_out);
      end
      @(negedge clk_32f);
      reset_L = 1'b1;
   endtask

   task automatic test_failed_align();
      base = vld_cnt;
      send_sym(COM);
      send_sym(COM);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL align_two_com: got locked=%b expected 0", locked);
      end
      send_sym(8'h55);
      checks++;
      if ({locked, idle_out} !== 2'b01) begin
         errors++;
         $display("FAIL align_broken: got locked/idle=%b expected 01", {locked, idle_out});
      end
      #3;
      checks++;
      if (vld_cnt != base) begin
         errors++;
         $display("FAIL align_no_valid: got %0d strobes expected 0", vld_cnt - base);
      end
   endtask

   task automatic test_lock_stripe();
      logic [7:0] d [4];
      logic [3:0] exp_v;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      repeat (3) send_sym(COM);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL lock_early: got locked=%b after 3 COM expected 0", locked);
      end
      send_sym(COM);
      checks++;
      if ({locked, idle_out} !== 2'b10) begin
         errors++;
         $display("FAIL lock_rise: got locked/idle=%b expected 10", {locked, idle_out});
      end
      base = vld_cnt;
      for (int i = 0; i < 4; i++) begin
         send_sym(d[i]);
         exp_v = 4'b0001 << i;
         checks++;
         if (valid_out !== exp_v || lane(i) !== d[i]) begin
            errors++;
            $display("FAIL stripe_%0d: got valid=%b lane=%h expected valid=%b lane=%h", i, valid_out, lane(i), exp_v, d[i]);
         end
      end
      #3;
      checks++;
      if (vld_cnt - base != 4 || data_out !== 32'h44332211) begin
         errors++;
         $display("FAIL stripe_total: got %0d strobes data=%h expected 4 strobes data=44332211", vld_cnt - base, data_out);
      end
   endtask

   task automatic test_locked_stream();
      base = vld_cnt;
      send_sym(8'hA1);
      checks++;
      if (valid_out !== 4'b0001 || lane(0) !== 8'hA1) begin
         errors++;
         $display("FAIL stream_a1: got valid=%b lane0=%h expected 0001 a1", valid_out, lane(0));
      end
      send_sym(IDLE);
      checks++;
      if (valid_out !== 4'b0000 || locked !== 1'b1) begin
         errors++;
         $display("FAIL stream_idle: got valid=%b locked=%b expected 0000 1", valid_out, locked);
      end
      send_sym(COM);
      send_sym(8'hB2);
      checks++;
      if (valid_out !== 4'b0001 || lane(0) !== 8'hB2 || lane(1) !== 8'h22) begin
         errors++;
         $display("FAIL stream_b2: got valid=%b lane0=%h lane1=%h expected 0001 b2 22", valid_out, lane(0), lane(1));
      end
      #3;
      checks++;
      if (vld_cnt - base != 2) begin
         errors++;
         $display("FAIL stream_count: got %0d strobes expected 2", vld_cnt - base);
      end
   endtask

   task automatic test_loss();
      logic [3:0] exp_v;
      send_sym(COM);
      for (int k = 1; k <= 16; k++) begin
         send_sym(8'h40 + 8'(k));
         exp_v = 4'b0001 << ((k - 1) % 4);
         checks++;
         if (valid_out !== exp_v || locked !== 1'b1) begin
            errors++;
            $display("FAIL gap_sym_%0d: got valid=%b locked=%b expected %b 1", k, valid_out, locked, exp_v);
         end
      end
      send_sym(8'h51);
`ifdef PHY_RX_LOSS_DET_EN
      checks++;
      if ({locked, idle_out, valid_out} !== 6'b0_1_0000 || lane(0) !== 8'h4D) begin
         errors++;
         $display("FAIL gap_loss: got locked/idle/valid=%b lane0=%h expected 010000 4d", {locked, idle_out, valid_out}, lane(0));
      end
`else
      checks++;
      if ({locked, idle_out, valid_out} !== 6'b1_0_0001 || lane(0) !== 8'h51) begin
         errors++;
         $display("FAIL gap_hold: got locked/idle/valid=%b lane0=%h expected 100001 51", {locked, idle_out, valid_out}, lane(0));
      end
`endif
   endtask

   task automatic test_async_reset();
      repeat (4) send_sym(COM);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL rst_prelock: got locked=%b expected 1", locked);
      end
      send_sym(8'h66);
      checks++;
      if (valid_out !== 4'b0001 || lane(0) !== 8'h66) begin
         errors++;
         $display("FAIL rst_pre_data: got valid=%b lane0=%h expected 0001 66", valid_out, lane(0));
      end
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      #2;
      reset_L = 1'b0;
      #1;
      checks++;
      if ({data_out, valid_out, idle_out, locked} !== {32'h0, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_async: got data=%h valid=%b idle=%b locked=%b expected 00000000 0000 1 0", data_out, valid_out, idle_out, locked);
      end
      @(posedge clk_32f);
      #1;
      reset_L = 1'b1;
      base = vld_cnt;
      send_sym(8'h33);
      send_sym(8'h33);
      repeat (3) send_sym(COM);
      checks++;
      if (locked !== 1'b0 || data_out !== 32'h0) begin
         errors++;
         $display("FAIL rst_ignore: got locked=%b data=%h expected 0 00000000", locked, data_out);
      end
      #3;
      checks++;
      if (vld_cnt != base) begin
         errors++;
         $display("FAIL rst_no_valid: got %0d strobes expected 0", vld_cnt - base);
      end
      send_sym(COM);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL rst_relock: got locked=%b expected 1", locked);
      end
      send_sym(8'h12);
      checks++;
      if (valid_out !== 4'b0001 || data_out !== 32'h00000012) begin
         errors++;
         $display("FAIL rst_post_data: got valid=%b data=%h expected 0001 00000012", valid_out, data_out);
      end
   endtask

   initial begin
      test_reset();
      test_failed_align();
      test_lock_stripe();
      test_locked_stream();
      test_loss();
      test_async_reset();
      #3;
      checks++;
      if (multi_cnt != 0) begin
         errors++;
         $display("FAIL one_hot_valid: got %0d multi-lane cycles expected 0", multi_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
